// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - host word stream to instruction memory loader with core hold and PC launch
module imem_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        load_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        pc_load,
    output logic [31:0] pc_init,
    output logic [15:0] words_loaded,
    output logic        err
);

    typedef enum logic [2:0] {
        S_HDR_PC,
        S_HDR_CNT,
        S_DATA,
        S_WAIT,
        S_LAUNCH,
        S_RUN,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_xfer;
    logic        r_in_ready;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_cpu_hold;
    logic        r_pc_load;
    logic [31:0] r_pc_init;
    logic [15:0] r_words_loaded;
    logic        r_err;
    logic [31:0] r_ptr;
    logic [31:0] r_remain;

    assign w_xfer       = in_valid && r_in_ready;
    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_hold     = r_cpu_hold;
    assign pc_load      = r_pc_load;
    assign pc_init      = r_pc_init;
    assign words_loaded = r_words_loaded;
    assign err          = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR_PC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR_PC: begin
                if (w_xfer) begin
                    w_next = (in_data[1:0] != 2'b00) ? S_ERR : S_HDR_CNT;
                end
            end
            S_HDR_CNT: begin
                if (w_xfer) begin
                    if (in_data == 32'd0) begin
                        w_next = S_LAUNCH;
                    end else if (in_data > 32'(MAX_WORDS)) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && r_remain == 32'd1) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT:   w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_RUN;
            S_RUN: begin
                if (load_req) begin
                    w_next = S_HDR_PC;
                end
            end
            S_ERR:    w_next = S_ERR;
            default:  w_next = S_HDR_PC;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= 32'd0;
            r_mem_wdata    <= 32'd0;
            r_cpu_hold     <= 1'b1;
            r_pc_load      <= 1'b0;
            r_pc_init      <= 32'd0;
            r_words_loaded <= 16'd0;
            r_err          <= 1'b0;
            r_ptr          <= 32'd0;
            r_remain       <= 32'd0;
        end else begin
            r_in_ready <= (w_next == S_HDR_PC) || (w_next == S_HDR_CNT) || (w_next == S_DATA);
            r_cpu_hold <= (w_next != S_RUN);
            r_pc_load  <= (w_next == S_LAUNCH);
            r_err      <= (w_next == S_ERR);
            r_mem_we   <= 1'b0;

            if (r_state == S_HDR_PC && w_xfer) begin
                r_pc_init <= in_data;
                r_ptr     <= in_data;
            end
            if (r_state == S_HDR_CNT && w_xfer) begin
                r_remain <= in_data;
            end
            if (r_state == S_DATA && w_xfer) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= in_data;
                r_ptr       <= r_ptr + 32'd4;
                r_remain    <= r_remain - 32'd1;
                if (r_words_loaded != 16'hFFFF) begin
                    r_words_loaded <= r_words_loaded + 16'd1;
                end
            end
            if (r_state == S_RUN && load_req) begin
                r_words_loaded <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    localparam int MAXW = 1024;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        load_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        pc_load;
    logic [31:0] pc_init;
    logic [15:0] words_loaded;
    logic        err;

    int checks;
    int failures;

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .load_req     (load_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .pc_load      (pc_load),
        .pc_init      (pc_init),
        .words_loaded (words_loaded),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, cross one rising edge, land on the next falling edge.
    task automatic step(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rearm();
        load_req = 1'b1;
        step(1'b0, 32'd0);
        load_req = 1'b0;
        chk("rearm_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rearm_ready", {31'd0, in_ready}, 32'd1);
        chk("rearm_words", {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 32'd0);
        rst_n = 1'b1;
        step(1'b0, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        load_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_pcload", {31'd0, pc_load}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        step(1'b0, 32'd0);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Full-rate load of three words at 800.
        step(1'b1, 32'd800);
        step(1'b1, 32'd3);
        chk("t1_no_we_hdr", {31'd0, mem_we}, 32'd0);
        step(1'b1, 32'h20100005);
        chk("t1_we0", {31'd0, mem_we}, 32'd1);
        chk("t1_addr0", mem_addr, 32'd800);
        chk("t1_data0", mem_wdata, 32'h20100005);
        step(1'b1, 32'h2011000A);
        chk("t1_we1", {31'd0, mem_we}, 32'd1);
        chk("t1_addr1", mem_addr, 32'd804);
        chk("t1_data1", mem_wdata, 32'h2011000A);
        step(1'b1, 32'h20120014);
        chk("t1_we2", {31'd0, mem_we}, 32'd1);
        chk("t1_addr2", mem_addr, 32'd808);
        chk("t1_data2", mem_wdata, 32'h20120014);
        chk("t1_ready_wait", {31'd0, in_ready}, 32'd0);
        chk("t1_pcload_wait", {31'd0, pc_load}, 32'd0);
        step(1'b1, 32'hDEADBEEF);
        chk("t1_we_off", {31'd0, mem_we}, 32'd0);
        chk("t1_pcload", {31'd0, pc_load}, 32'd1);
        chk("t1_pcinit", pc_init, 32'd800);
        chk("t1_hold_launch", {31'd0, cpu_hold}, 32'd1);
        step(1'b0, 32'd0);
        chk("t1_pcload_off", {31'd0, pc_load}, 32'd0);
        chk("t1_hold_run", {31'd0, cpu_hold}, 32'd0);
        chk("t1_words", {16'd0, words_loaded}, 32'd3);
        step(1'b0, 32'd0);
        chk("t1_run_stable", {31'd0, pc_load}, 32'd0);

        // Same stream with in_valid toggling every cycle.
        rearm();
        step(1'b1, 32'd800);
        step(1'b0, 32'd0);
        step(1'b1, 32'd3);
        step(1'b0, 32'd0);
        step(1'b1, 32'h20100005);
        chk("t2_addr0", mem_addr, 32'd800);
        chk("t2_we0", {31'd0, mem_we}, 32'd1);
        step(1'b0, 32'h11111111);
        chk("t2_gap0", {31'd0, mem_we}, 32'd0);
        step(1'b1, 32'h2011000A);
        chk("t2_addr1", mem_addr, 32'd804);
        chk("t2_data1", mem_wdata, 32'h2011000A);
        step(1'b0, 32'h22222222);
        chk("t2_gap1", {31'd0, mem_we}, 32'd0);
        step(1'b1, 32'h20120014);
        chk("t2_addr2", mem_addr, 32'd808);
        chk("t2_data2", mem_wdata, 32'h20120014);
        step(1'b0, 32'd0);
        chk("t2_pcload", {31'd0, pc_load}, 32'd1);
        step(1'b0, 32'd0);
        chk("t2_hold_run", {31'd0, cpu_hold}, 32'd0);
        chk("t2_words", {16'd0, words_loaded}, 32'd3);

        // Write pointer wraps past the top of the address space.
        rearm();
        step(1'b1, 32'hFFFFFFFC);
        step(1'b1, 32'd2);
        step(1'b1, 32'hAAAA0001);
        chk("wrap_addr0", mem_addr, 32'hFFFFFFFC);
        step(1'b1, 32'hAAAA0002);
        chk("wrap_addr1", mem_addr, 32'h00000000);
        chk("wrap_data1", mem_wdata, 32'hAAAA0002);
        step(1'b0, 32'd0);
        step(1'b0, 32'd0);
        chk("wrap_err", {31'd0, err}, 32'd0);
        chk("wrap_run", {31'd0, cpu_hold}, 32'd0);

        // Zero count launches directly.
        rearm();
        step(1'b1, 32'd400);
        step(1'b1, 32'd0);
        chk("z_pcload", {31'd0, pc_load}, 32'd1);
        chk("z_pcinit", pc_init, 32'd400);
        chk("z_no_we", {31'd0, mem_we}, 32'd0);
        chk("z_ready", {31'd0, in_ready}, 32'd0);
        step(1'b0, 32'd0);
        chk("z_run", {31'd0, cpu_hold}, 32'd0);
        chk("z_words", {16'd0, words_loaded}, 32'd0);

        // Count of exactly MAX_WORDS is accepted.
        rearm();
        step(1'b1, 32'h1000);
        step(1'b1, 32'(MAXW));
        for (int i = 0; i < MAXW; i++) step(1'b1, 32'(i));
        chk("max_last_addr", mem_addr, 32'h1000 + 32'(4 * (MAXW - 1)));
        step(1'b0, 32'd0);
        step(1'b0, 32'd0);
        chk("max_words", {16'd0, words_loaded}, 32'(MAXW));
        chk("max_run", {31'd0, cpu_hold}, 32'd0);
        chk("max_err", {31'd0, err}, 32'd0);

        // Misaligned start PC is an error.
        rearm();
        step(1'b1, 32'd802);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 32'd1);
        step(1'b1, 32'h12345678);
        load_req = 1'b1;
        step(1'b1, 32'h12345678);
        load_req = 1'b0;
        chk("mis_no_we", {31'd0, mem_we}, 32'd0);
        chk("mis_no_pcload", {31'd0, pc_load}, 32'd0);
        chk("mis_hold", {31'd0, cpu_hold}, 32'd1);
        chk("mis_sticky", {31'd0, err}, 32'd1);

        // Count above MAX_WORDS is an error.
        do_reset();
        chk("cnt_rst_err", {31'd0, err}, 32'd0);
        step(1'b1, 32'd0);
        step(1'b1, 32'(MAXW + 1));
        chk("cnt_err", {31'd0, err}, 32'd1);
        chk("cnt_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 32'h1);
        step(1'b0, 32'd0);
        chk("cnt_no_we", {31'd0, mem_we}, 32'd0);
        chk("cnt_no_pcload", {31'd0, pc_load}, 32'd0);
        chk("cnt_hold", {31'd0, cpu_hold}, 32'd1);

        // Reset in the middle of a load.
        do_reset();
        step(1'b1, 32'd800);
        step(1'b1, 32'd3);
        step(1'b1, 32'h20100005);
        step(1'b1, 32'h2011000A);
        chk("mid_we_before", {31'd0, mem_we}, 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_we", {31'd0, mem_we}, 32'd0);
        chk("mid_addr", mem_addr, 32'd0);
        chk("mid_wdata", mem_wdata, 32'd0);
        chk("mid_hold", {31'd0, cpu_hold}, 32'd1);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_pcinit", pc_init, 32'd0);
        chk("mid_words", {16'd0, words_loaded}, 32'd0);
        @(negedge clk);
        step(1'b0, 32'd0);
        chk("mid_no_pcload", {31'd0, pc_load}, 32'd0);
        rst_n = 1'b1;
        step(1'b0, 32'd0);
        step(1'b1, 32'd800);
        step(1'b1, 32'd1);
        step(1'b1, 32'h0BADF00D);
        chk("re_we", {31'd0, mem_we}, 32'd1);
        chk("re_addr", mem_addr, 32'd800);
        chk("re_data", mem_wdata, 32'h0BADF00D);
        step(1'b0, 32'd0);
        chk("re_pcload", {31'd0, pc_load}, 32'd1);
        step(1'b0, 32'd0);
        chk("re_run", {31'd0, cpu_hold}, 32'd0);
        chk("re_words", {16'd0, words_loaded}, 32'd1);
        rearm();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side program loader for the modified MIPS core: accepts a stream of 32-bit words (start PC, word count, instruction words), writes the instructions into instruction memory, and holds the core stalled until loading completes. It then pulses a PC-load so the core starts fetching at the supplied start address, e.g. 800. It is the writer counterpart to the bench-side result readers and sits between the test host and `Top`'s instruction-memory write port and PC-init logic.

## Interface
- `MAX_WORDS`, default 1024: largest accepted word count; a count above this is an error.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: host word valid.
- `in_data` in 32: host word.
- `in_ready` out 1: loader can accept `in_data` this cycle.
- `load_req` in 1: re-arm the loader from RUN (level sampled).
- `mem_we` out 1: instruction-memory write enable.
- `mem_addr` out 32: byte address, word aligned.
- `mem_wdata` out 32: instruction word.
- `cpu_hold` out 1: stall the core while high.
- `pc_load` out 1: one-cycle pulse; core PC <= `pc_init`.
- `pc_init` out 32: start PC.
- `words_loaded` out 16: words written in the current load.
- `err` out 1: sticky load error.

## Operation
- A transfer occurs on a rising edge with `in_valid && in_ready`.
- States: HDR_PC, HDR_CNT, DATA, WAIT, LAUNCH, RUN, ERR.
- HDR_PC: first accepted word is latched into `pc_init` and the write pointer.
  - If `in_data[1:0] != 0` -> ERR; otherwise -> HDR_CNT.
- HDR_CNT: accepted word is the count N.
  - N == 0 -> LAUNCH.
  - N > MAX_WORDS -> ERR.
  - Otherwise latch N and go -> DATA.
- DATA: each accepted word is written to the write pointer, then the pointer advances by 4. The pointer wraps modulo 2^32, with no error on wrap.
  - After the Nth word is accepted -> WAIT.
- WAIT: one cycle while the final write completes, then -> LAUNCH.
- LAUNCH: one cycle with `pc_load` = 1, then -> RUN.
- RUN: `cpu_hold` = 0. If `load_req` = 1 -> HDR_PC, clear `words_loaded`, set `cpu_hold` = 1.
- ERR: `err` = 1 and `cpu_hold` = 1. Only `rst_n` exits this state.
- `in_ready` = 1 only in HDR_PC, HDR_CNT and DATA.
- `load_req` is ignored outside RUN. In-flight data is never dropped.
- `words_loaded` increments with each `mem_we` pulse and saturates at 16'hFFFF.

## Timing
- Reset (async assert, values held while `rst_n` = 0): state = HDR_PC, `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_hold` = 1, `pc_load` = 0, `pc_init` = 0, `words_loaded` = 0, `err` = 0.
- `in_ready` rises in the first cycle after `rst_n` deasserts.
- All outputs are registered.
- Write latency: a data word accepted at edge k gives `mem_we` = 1 with matching `mem_addr`/`mem_wdata` for the cycle after edge k. `mem_we` drops on the next edge unless another word is accepted.
- Back-to-back accepts produce back-to-back writes, one per cycle, at full rate.
- Final word accepted at edge t:
  - After t: final `mem_we` high; state WAIT.
  - After t+1: `pc_load` = 1 (LAUNCH).
  - After t+2: `pc_load` = 0, `cpu_hold` = 0 (RUN).
- N == 0, count accepted at edge t: `pc_load` = 1 after t, `cpu_hold` = 0 after t+1. No writes occur.
- `rst_n` asserted mid-load: outputs return to reset values immediately. A partial load is abandoned and `pc_load` never fires.
- `load_req` in RUN sampled at edge t: `cpu_hold` = 1 and `in_ready` = 1 after t.

## Test plan
- Stream 800, 3, 0x20100005, 0x2011000A, 0x20120014 with `in_valid` held:
  - writes at addresses 800, 804, 808 on consecutive cycles;
  - `pc_init` = 800, single `pc_load` pulse 2 cycles after the last accept;
  - `cpu_hold` falls the cycle after; `words_loaded` = 3.
- Same stream with `in_valid` toggling 1/0 each cycle:
  - identical writes spaced 2 cycles apart;
  - no write during `in_valid` = 0 cycles.
- Start PC 802 -> `err` = 1, `in_ready` = 0, `cpu_hold` stays 1, no writes, no `pc_load`. Count MAX_WORDS+1 after start PC 0 -> same response.
- Start 0xFFFFFFFC, count 2 -> writes at 0xFFFFFFFC then 0x00000000.
- Count 0 after start 400 -> no `mem_we`, `pc_load` with `pc_init` = 400, then RUN.
- Assert `rst_n` low after the 2nd of 3 data words -> all outputs at reset values at once.
  - After release, reload 800/1/word -> one write at 800.
  - `load_req` in RUN re-arms with `words_loaded` = 0.
